sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter: AW, 8, address width; depth = 2**AW.
REQ-002 SHALL have parameter: AF_TH, 252, almost_full threshold (entries).
REQ-003 SHALL have parameter: AE_TH, 4, almost_empty threshold (entries).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port: wr_en  in  1  write request.
REQ-006 SHALL have port: rd_en  in  1  read request.
REQ-007 SHALL have port: ram_wce  out  1  RAM write strobe.
REQ-008 SHALL have port: ram_waddr  out  AW  RAM write address.
REQ-009 SHALL have port: ram_rce  out  1  RAM read strobe.
REQ-010 SHALL have port: ram_raddr  out  AW  RAM read address.
REQ-011 SHALL have port: full  out  1  depth entries stored.
REQ-012 SHALL have port: empty  out  1  zero entries stored.
REQ-013 SHALL have port: almost_full  out  1  count >= AF_TH.
REQ-014 SHALL have port: almost_empty  out  1  count <= AE_TH.
REQ-015 SHALL have port: count  out  AW+1  stored entries.
REQ-016 SHALL have port: rd_valid  out  1  RAM output data valid this cycle.
REQ-017 SHALL have port: overflow  out  1  sticky error, write while full.
REQ-018 SHALL have port: underflow  out  1  sticky error, read while empty.

Function
REQ-019 SHALL drive a RAM with a 1-cycle registered read: data appears the cycle after its read strobe.
REQ-020 SHALL accept a write when wr_en=1 and full=0; ram_wce = wr_en & ~full (combinational); ram_waddr = wptr[AW-1:0].
REQ-021 SHALL accept a read when rd_en=1 and empty=0; ram_rce = rd_en & ~empty (combinational); ram_raddr = rptr[AW-1:0].
REQ-022 SHALL keep wptr and rptr AW+1 bits wide, each incrementing by 1 per accepted operation and wrapping modulo 2**(AW+1).
REQ-023 SHALL register full, empty, almost_full, almost_empty and count, all updated on the edge of the accepted operation.
REQ-024 SHALL define full as (wptr-rptr)==2**AW and empty as wptr==rptr; count = wptr-rptr, mod 2**(AW+1).
REQ-025 SHALL, on a simultaneous accepted read and write, hold count and flags and advance both pointers.
REQ-026 SHALL, when full and both wr_en and rd_en are asserted, accept only the read; count decrements.
REQ-027 SHALL, when empty and both are asserted, accept only the write; count increments.
REQ-028 SHALL ignore rejected requests: pointers and count unchanged, no RAM strobe.
REQ-029 SHALL assert rd_valid exactly one cycle after each cycle with ram_rce=1, otherwise 0.
REQ-030 SHALL wrap addresses from 2**AW-1 to 0 with no bubble.

Reset
REQ-031 SHALL, with rst=1 at a rising edge, set wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, overflow=0, underflow=0.
REQ-032 SHALL force ram_wce=0 and ram_rce=0 while rst=1, with reset taking priority over any simultaneous request; mid-operation reset discards all contents.

Configuration
REQ-033 SHALL, with macro SYNC_FIFO_ERR_FLAGS_EN defined, set overflow on wr_en & full and underflow on rd_en & empty, both sticky until rst.
REQ-034 SHALL, without SYNC_FIFO_ERR_FLAGS_EN, tie overflow and underflow to 0 and contain no error-flag logic.

Verification (AW=2, AF_TH=3, AE_TH=1)
REQ-035 SHALL cover: after reset, 4 writes -> ram_waddr 0,1,2,3; count=4; full=1, almost_full=1 after the 4th edge; empty=0.
REQ-036 SHALL cover: 5th write while full -> ram_wce=0, count stays 4; overflow=1 when SYNC_FIFO_ERR_FLAGS_EN is defined, 0 otherwise.
REQ-037 SHALL cover: full, wr_en=rd_en=1 for one cycle -> read of addr 0 only; count=3, full=0; rd_valid=1 the next cycle.
REQ-038 SHALL cover: empty, wr_en=rd_en=1 -> write only; count=1, empty=0, rd_valid=0 the next cycle.
REQ-039 SHALL cover: 6 write-then-read pairs from reset -> addresses wrap 3->0; empty=1 and count=0 at the end.
REQ-040 SHALL cover: count=2, rst=1 with wr_en=1 -> next cycle count=0, empty=1, ram_wce=0 during reset.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external RAM with a 1-cycle registered read.
// Optional sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_ctrl #(
    parameter int AW    = 8,
    parameter int AF_TH = 252,
    parameter int AE_TH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          ram_wce,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_rce,
    output logic [AW-1:0] ram_raddr,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          rd_valid,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_TH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_TH);

    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;
    logic [AW:0] count_r;
    logic        full_r;
    logic        empty_r;
    logic        almost_full_r;
    logic        almost_empty_r;
    logic        rd_valid_r;

    logic        wr_acc_s;
    logic        rd_acc_s;
    logic [AW:0] wptr_nxt_s;
    logic [AW:0] rptr_nxt_s;
    logic [AW:0] count_nxt_s;

    // Accept decisions and next pointer/count; reset blocks every request.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (rst) begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end else begin
            wr_acc_s = wr_en & ~full_r;
            rd_acc_s = rd_en & ~empty_r;
        end
        wptr_nxt_s  = wptr_r + {{AW{1'b0}}, wr_acc_s};
        rptr_nxt_s  = rptr_r + {{AW{1'b0}}, rd_acc_s};
        count_nxt_s = wptr_nxt_s - rptr_nxt_s;
    end

    // Pointer, occupancy flag and read-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r         <= ZERO_C;
            rptr_r         <= ZERO_C;
            count_r        <= ZERO_C;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            rd_valid_r     <= 1'b0;
        end else begin
            wptr_r         <= wptr_nxt_s;
            rptr_r         <= rptr_nxt_s;
            count_r        <= count_nxt_s;
            full_r         <= (count_nxt_s == DEPTH_C);
            empty_r        <= (count_nxt_s == ZERO_C);
            almost_full_r  <= (count_nxt_s >= AF_C);
            almost_empty_r <= (count_nxt_s <= AE_C);
            rd_valid_r     <= rd_acc_s;
        end
    end

    assign ram_wce      = wr_acc_s;
    assign ram_rce      = rd_acc_s;
    assign ram_waddr    = wptr_r[AW-1:0];
    assign ram_raddr    = rptr_r[AW-1:0];
    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign rd_valid     = rd_valid_r;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | (wr_en & full_r);
            underflow_r <= underflow_r | (rd_en & empty_r);
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (AW=2): directed corner cases then randomized traffic
// compared against an occupancy/transaction-count reference model.
module tb_sync_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF_TH = 3;
    localparam int AE_TH = 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic          ram_wce;
    logic [AW-1:0] ram_waddr;
    logic          ram_rce;
    logic [AW-1:0] ram_raddr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          rd_valid;
    logic          overflow;
    logic          underflow;

    int n_checks;
    int n_errors;

    // Reference model state: occupancy and totals of accepted operations since reset.
    int m_count;
    int m_writes;
    int m_reads;
    bit m_rd_valid;
    bit m_ovf;
    bit m_udf;

    sync_fifo_ctrl #(.AW(AW), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .ram_wce(ram_wce), .ram_waddr(ram_waddr), .ram_rce(ram_rce), .ram_raddr(ram_raddr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .rd_valid(rd_valid), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check strobes before the edge, update model, check registers after.
    task automatic cycle(input bit w, input bit r, input bit rs);
        bit exp_wce;
        bit exp_rce;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        rst   = rs;
        #1;
        exp_wce = w && !rs && (m_count != DEPTH);
        exp_rce = r && !rs && (m_count != 0);
        check_eq("ram_wce", 32'(ram_wce), 32'(exp_wce));
        check_eq("ram_rce", 32'(ram_rce), 32'(exp_rce));
        if (exp_wce) check_eq("ram_waddr", 32'(ram_waddr), 32'(m_writes % DEPTH));
        if (exp_rce) check_eq("ram_raddr", 32'(ram_raddr), 32'(m_reads % DEPTH));
        @(posedge clk);
        if (rs) begin
            m_count = 0; m_writes = 0; m_reads = 0;
            m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (w && m_count == DEPTH) m_ovf = 1'b1;
            if (r && m_count == 0) m_udf = 1'b1;
`endif
            m_rd_valid = exp_rce;
            m_count    = m_count + int'(exp_wce) - int'(exp_rce);
            m_writes   = m_writes + int'(exp_wce);
            m_reads    = m_reads + int'(exp_rce);
        end
        #1;
        check_eq("count", 32'(count), 32'(m_count));
        check_eq("full", 32'(full), 32'(m_count == DEPTH));
        check_eq("empty", 32'(empty), 32'(m_count == 0));
        check_eq("almost_full", 32'(almost_full), 32'(m_count >= AF_TH));
        check_eq("almost_empty", 32'(almost_empty), 32'(m_count <= AE_TH));
        check_eq("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_udf));
    endtask

    initial begin
        bit w;
        bit r;
        bit rs;
        n_checks = 0; n_errors = 0;
        m_count = 0; m_writes = 0; m_reads = 0;
        m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; rst = 1'b1;

        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);

        // Fill to full, then write while full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        check_eq("fill_count", 32'(count), 32'd4);
        check_eq("fill_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("ovf_count", 32'(count), 32'd4);

        // Full with both requests: only the read of address 0.
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("full_rw_count", 32'(count), 32'd3);
        check_eq("full_rw_rdvalid", 32'(rd_valid), 32'd1);

        // Drain, read while empty, then both requests on empty.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("empty_rw_count", 32'(count), 32'd1);
        check_eq("empty_rw_rdvalid", 32'(rd_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);

        // Six write/read pairs from reset: addresses wrap 3 -> 0.
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
        end
        check_eq("pairs_count", 32'(count), 32'd0);
        check_eq("pairs_empty", 32'(empty), 32'd1);

        // Reset mid-operation with a pending write.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        check_eq("rst_count", 32'(count), 32'd0);

        // Randomized traffic, alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 600; i++) begin
            if (((i / 40) % 2) == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            rs = ($urandom_range(0, 99) == 0);
            cycle(w, r, rs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
